// File: rtl/core_pkg.sv
// Shared ALU control codes and execute-stage types; the decoder consumes the same constants.
package core_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_SLT  = 5'b10111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the shifter: moves a value by 0..STEP bit positions.
module alu_shift_step
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic [XLEN-1:0] i_value,
    input  logic [5:0]      i_amt,
    input  shift_kind_t     i_kind,
    output logic [XLEN-1:0] o_value
);

    // Only distances up to STEP are decoded, keeping the mux small for small STEP.
    always_comb begin
        o_value = i_value;
        for (int k = 1; k <= STEP; k++) begin
            if (i_amt == 6'(k)) begin
                case (i_kind)
                    SH_LL:   o_value = i_value << k;
                    SH_RL:   o_value = i_value >> k;
                    default: o_value = $signed(i_value) >>> k;
                endcase
            end
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, iterative shifts, valid/ready on both sides.
// Handshake: a request is taken on a clock edge where i_valid && o_ready; a result retires on an edge where o_valid && i_ready.
module iterative_alu
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_control,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output alu_state_t      o_state
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    alu_state_t      r_state;
    alu_state_t      w_next_state;
    alu_state_t      w_start_state;
    logic [XLEN-1:0] r_result;
    logic [5:0]      r_cnt;
    shift_kind_t     r_kind;

    logic [4:0]      w_shamt;
    logic            w_is_shift;
    shift_kind_t     w_kind;
    logic            w_accept;
    logic [XLEN-1:0] w_alu;
    logic [5:0]      w_step_amt;
    logic [5:0]      w_cnt_next;
    logic [XLEN-1:0] w_shifted;

    assign w_shamt  = i_op_b[4:0];
    assign o_ready  = !i_flush && ((r_state == IDLE) || ((r_state == DONE) && i_ready));
    assign w_accept = i_valid && o_ready;
    assign o_valid  = (r_state == DONE);
    assign o_result = r_result;
    assign o_zero   = (r_result == '0);
    assign o_state  = r_state;

    always_comb begin
        w_is_shift = 1'b0;
        w_kind     = SH_LL;
        case (i_alu_control)
            ALU_SLL: begin w_is_shift = 1'b1; w_kind = SH_LL; end
            ALU_SRL: begin w_is_shift = 1'b1; w_kind = SH_RL; end
            ALU_SRA: begin w_is_shift = 1'b1; w_kind = SH_RA; end
            default: ;
        endcase
    end

    // Shifts only land here with a zero distance, so they pass operand A through.
    always_comb begin
        w_alu = i_op_a + i_op_b;
        case (i_alu_control)
            ALU_SUB:  w_alu = i_op_a - i_op_b;
            ALU_AND:  w_alu = i_op_a & i_op_b;
            ALU_OR:   w_alu = i_op_a | i_op_b;
            ALU_XOR:  w_alu = i_op_a ^ i_op_b;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu = i_op_a;
            default:  ;
        endcase
    end

    assign w_step_amt = (r_cnt > STEP_W) ? STEP_W : r_cnt;
    assign w_cnt_next = r_cnt - w_step_amt;

    alu_shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_shift_step (
        .i_value (r_result),
        .i_amt   (w_step_amt),
        .i_kind  (r_kind),
        .o_value (w_shifted)
    );

    assign w_start_state = (w_is_shift && (w_shamt != 5'd0)) ? SHIFT : DONE;

    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_next_state = w_start_state;
                SHIFT:   if (w_cnt_next == 6'd0) w_next_state = DONE;
                DONE: begin
                    if (w_accept)     w_next_state = w_start_state;
                    else if (i_ready) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_cnt    <= 6'd0;
            r_kind   <= SH_LL;
        end else begin
            r_state <= w_next_state;
            if (i_flush) begin
                r_cnt <= 6'd0;
            end else if (w_accept) begin
                // r_result doubles as the shift accumulator while in SHIFT.
                if (w_start_state == SHIFT) begin
                    r_result <= i_op_a;
                    r_cnt    <= {1'b0, w_shamt};
                    r_kind   <= w_kind;
                end else begin
                    r_result <= w_alu;
                end
            end else if (r_state == SHIFT) begin
                r_result <= w_shifted;
                r_cnt    <= w_cnt_next;
            end
        end
    end

endmodule
